// File: rtl/maxpool_pkg.sv
//------------------------------------------------------------------------------
// Module  : cnn_defs (package)
// Brief   : Shared pooling constants and pooling FSM state encoding.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cnn_defs;

    localparam int POOL_HEIGHT   = 2;
    localparam int POOL_WIDTH    = 2;
    localparam int POOL_H_STRIDE = 2;
    localparam int POOL_V_STRIDE = 2;

    typedef enum logic [1:0] {
        POOL_IDLE    = 2'd0,
        POOL_PROCESS = 2'd1,
        POOL_DONE    = 2'd2
    } pool_state_t;

endpackage

`default_nettype wire

// File: rtl/maxpool_pool_max.sv
//------------------------------------------------------------------------------
// Module  : pool_max
// Brief   : Combinational unsigned maximum over a pooling window.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pool_max #(
    parameter int DATA_WIDTH  = 8,
    parameter int POOL_HEIGHT = 2,
    parameter int POOL_WIDTH  = 2
) (
    input  logic [DATA_WIDTH-1:0] window [0:POOL_HEIGHT-1][0:POOL_WIDTH-1],
    output logic [DATA_WIDTH-1:0] max_val
);

    logic [DATA_WIDTH-1:0] w_max;

    always_comb begin
        w_max = window[0][0];
        for (int i = 0; i < POOL_HEIGHT; i++) begin
            for (int j = 0; j < POOL_WIDTH; j++) begin
                if (window[i][j] > w_max) begin
                    w_max = window[i][j];
                end
            end
        end
    end

    assign max_val = w_max;

endmodule

`default_nettype wire

// File: rtl/maxpool.sv
//------------------------------------------------------------------------------
// Module  : maxpool
// Brief   : Walks the pooled output grid one pixel per cycle, registering the
//           window maximum into ofmap, then raises done_pool.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module maxpool #(
    parameter int IFMAP_HEIGHT = 6,
    parameter int IFMAP_WIDTH  = 6,
    parameter int POOL_HEIGHT  = cnn_defs::POOL_HEIGHT,
    parameter int POOL_WIDTH   = cnn_defs::POOL_WIDTH,
    parameter int DATA_WIDTH   = 8,
    parameter int H_STRIDE     = cnn_defs::POOL_H_STRIDE,
    parameter int V_STRIDE     = cnn_defs::POOL_V_STRIDE,
    parameter int OFMAP_HEIGHT = (IFMAP_HEIGHT - POOL_HEIGHT) / V_STRIDE + 1,
    parameter int OFMAP_WIDTH  = (IFMAP_WIDTH - POOL_WIDTH) / H_STRIDE + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] ifmap [0:IFMAP_HEIGHT-1][0:IFMAP_WIDTH-1],
    output logic [DATA_WIDTH-1:0] ofmap [0:OFMAP_HEIGHT-1][0:OFMAP_WIDTH-1],
    output logic                  done_pool
);

    import cnn_defs::*;

    localparam int ROW_W  = (OFMAP_HEIGHT > 1) ? $clog2(OFMAP_HEIGHT) : 1;
    localparam int COL_W  = (OFMAP_WIDTH  > 1) ? $clog2(OFMAP_WIDTH)  : 1;
    localparam int IROW_W = (IFMAP_HEIGHT > 1) ? $clog2(IFMAP_HEIGHT) : 1;
    localparam int ICOL_W = (IFMAP_WIDTH  > 1) ? $clog2(IFMAP_WIDTH)  : 1;

    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(OFMAP_HEIGHT - 1);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(OFMAP_WIDTH - 1);

    pool_state_t           r_state;
    logic [ROW_W-1:0]      r_out_row;
    logic [COL_W-1:0]      r_out_col;
    logic [DATA_WIDTH-1:0] w_window [0:POOL_HEIGHT-1][0:POOL_WIDTH-1];
    logic [DATA_WIDTH-1:0] w_max;

    // Window origin follows the output counters; trailing rows/columns that
    // cannot fill a whole window are never addressed.
    always_comb begin
        for (int i = 0; i < POOL_HEIGHT; i++) begin
            for (int j = 0; j < POOL_WIDTH; j++) begin
                w_window[i][j] = ifmap[IROW_W'(int'(r_out_row) * V_STRIDE + i)]
                                      [ICOL_W'(int'(r_out_col) * H_STRIDE + j)];
            end
        end
    end

    pool_max #(
        .DATA_WIDTH  (DATA_WIDTH),
        .POOL_HEIGHT (POOL_HEIGHT),
        .POOL_WIDTH  (POOL_WIDTH)
    ) u_pool_max (
        .window  (w_window),
        .max_val (w_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= POOL_IDLE;
            r_out_row <= '0;
            r_out_col <= '0;
            for (int r = 0; r < OFMAP_HEIGHT; r++) begin
                for (int c = 0; c < OFMAP_WIDTH; c++) begin
                    ofmap[r][c] <= '0;
                end
            end
        end else if (!en) begin
            r_state   <= POOL_IDLE;
            r_out_row <= '0;
            r_out_col <= '0;
        end else begin
            case (r_state)
                POOL_IDLE: begin
                    r_state <= POOL_PROCESS;
                end
                POOL_PROCESS: begin
                    ofmap[r_out_row][r_out_col] <= w_max;
                    // Counters park on the last pixel so they read frozen in DONE.
                    if (r_out_col == c_COL_LAST) begin
                        if (r_out_row == c_ROW_LAST) begin
                            r_state <= POOL_DONE;
                        end else begin
                            r_out_col <= '0;
                            r_out_row <= r_out_row + 1'b1;
                        end
                    end else begin
                        r_out_col <= r_out_col + 1'b1;
                    end
                end
                POOL_DONE: begin
                    r_state <= POOL_DONE;
                end
                default: begin
                    r_state <= POOL_IDLE;
                end
            endcase
        end
    end

    assign done_pool = (r_state == POOL_DONE);

endmodule

`default_nettype wire

// File: tb/tb_maxpool.sv
//------------------------------------------------------------------------------
// Module  : tb_maxpool
// Brief   : Directed self-checking bench for maxpool (6x6 and 5x5 instances).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_maxpool;

    logic       clk;
    logic       reset;
    logic       en_a;
    logic       en_b;
    logic [7:0] ifmap_a [0:5][0:5];
    logic [7:0] ifmap_b [0:4][0:4];
    logic [7:0] ofmap_a [0:2][0:2];
    logic [7:0] ofmap_b [0:1][0:1];
    logic       done_a;
    logic       done_b;

    int errors = 0;
    int checks = 0;

    int exp_ramp  [9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    int exp_ext   [9] = '{1, 1, 1, 1, 255, 1, 1, 1, 1};
    int exp_abort [9] = '{7, 9, 11, 19, 0, 0, 0, 0, 0};
    int exp_zero  [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int exp_b     [4] = '{6, 8, 16, 18};

    maxpool #(
        .IFMAP_HEIGHT (6),
        .IFMAP_WIDTH  (6),
        .DATA_WIDTH   (8)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .en        (en_a),
        .ifmap     (ifmap_a),
        .ofmap     (ofmap_a),
        .done_pool (done_a)
    );

    maxpool #(
        .IFMAP_HEIGHT (5),
        .IFMAP_WIDTH  (5),
        .DATA_WIDTH   (8)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .en        (en_b),
        .ifmap     (ifmap_b),
        .ofmap     (ofmap_b),
        .done_pool (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_map_a(input string tag, input int exp [9]);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("%s ofmap[%0d][%0d]", tag, r, c),
                      int'(ofmap_a[r][c]), exp[r*3+c]);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_ramp_a();
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                ifmap_a[i][j] = 8'(i*6 + j);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        load_ramp_a();
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                ifmap_b[i][j] = 8'(i*5 + j);
            end
        end
        tick(2);
        check("reset done_pool", int'(done_a), 0);
        check_map_a("reset", exp_zero);
        reset = 1'b0;

        // Ramp 6x6: done rises exactly on the 10th edge
        en_a = 1'b1;
        tick(9);
        check("ramp done before 10th edge", int'(done_a), 0);
        tick(1);
        check("ramp done at 10th edge", int'(done_a), 1);
        check_map_a("ramp", exp_ramp);

        // Hold in DONE while ifmap changes
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    ifmap_a[i][j] = 8'($urandom_range(0, 255));
                end
            end
            tick(1);
            check($sformatf("hold done cycle %0d", k), int'(done_a), 1);
        end
        check_map_a("hold", exp_ramp);
        check("hold row frozen", int'(dut_a.r_out_row), 2);
        check("hold col frozen", int'(dut_a.r_out_col), 2);

        // Unsigned extremes in window (1,1)
        en_a = 1'b0;
        tick(1);
        check("extremes idle done", int'(done_a), 0);
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                ifmap_a[i][j] = 8'd1;
            end
        end
        ifmap_a[2][2] = 8'd255;
        ifmap_a[2][3] = 8'd0;
        ifmap_a[3][2] = 8'd128;
        ifmap_a[3][3] = 8'd127;
        en_a = 1'b1;
        tick(10);
        check("extremes done", int'(done_a), 1);
        check_map_a("extremes", exp_ext);

        // Abort after 4 PROCESS edges, then rerun
        reset = 1'b1;
        #2;
        reset = 1'b0;
        en_a = 1'b0;
        load_ramp_a();
        tick(1);
        en_a = 1'b1;
        tick(5);
        en_a = 1'b0;
        tick(1);
        check("abort done", int'(done_a), 0);
        check("abort row cleared", int'(dut_a.r_out_row), 0);
        check("abort col cleared", int'(dut_a.r_out_col), 0);
        check_map_a("abort", exp_abort);
        en_a = 1'b1;
        tick(9);
        check("rerun done before 10th edge", int'(done_a), 0);
        tick(1);
        check("rerun done", int'(done_a), 1);
        check_map_a("rerun", exp_ramp);

        // Asynchronous reset mid-PROCESS
        en_a = 1'b0;
        tick(1);
        en_a = 1'b1;
        tick(4);
        #2;
        reset = 1'b1;
        #1;
        check("async reset done", int'(done_a), 0);
        check("async reset row", int'(dut_a.r_out_row), 0);
        check("async reset col", int'(dut_a.r_out_col), 0);
        check_map_a("async reset", exp_zero);
        tick(1);
        reset = 1'b0;
        tick(10);
        check("post reset done", int'(done_a), 1);
        check_map_a("post reset", exp_ramp);

        // 5x5 map with floor behaviour
        en_b = 1'b1;
        tick(4);
        check("5x5 done before 5th edge", int'(done_b), 0);
        tick(1);
        check("5x5 done", int'(done_b), 1);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                check($sformatf("5x5 ofmap[%0d][%0d]", r, c),
                      int'(ofmap_b[r][c]), exp_b[r*2+c]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
